ptp_ts_queue: RTL and testbench

// - Downstream consumer of the PTP real-time clock: latches the 80-bit {sec[47:0],ns[31:0]} timestamp at each SFD strobe.
// - Pairs the timestamp with the PTP header fields (messageType, sequenceId) delivered later by the frame parser.
// - Queues completed records in a FIFO for host readout. One instance per direction (TX, RX).

---
 rtl/ptp_ts_queue.sv | 149 ++++++++++++++
 tb/tb_ptp_ts_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptp_ts_queue.sv
// Latches the RTC timestamp at each SFD, pairs it with the later PTP header fields and queues the record for the host.
// Build option: define PTP_TSQ_EVENT_FILTER_EN to keep only event messages (messageType 0..3).
module ptp_ts_queue #(
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 3,
  parameter int HDR_TIMEOUT = 64
) (
  input  logic              ptp_clk,
  input  logic              ptp_rst_n,
  input  logic              sfd_stb,
  input  logic [79:0]       ts_in,
  input  logic              hdr_vld,
  input  logic              hdr_is_ptp,
  input  logic [3:0]        hdr_msg_type,
  input  logic [15:0]       hdr_seq_id,
  input  logic              frm_abort,
  input  logic              pop,
  output logic              q_vld,
  output logic [79:0]       q_ts,
  output logic [3:0]        q_msg_type,
  output logic [15:0]       q_seq_id,
  output logic [ADDR_W:0]   q_count,
  output logic              ovf,
  output logic [7:0]        drop_cnt,
  input  logic              clr_stat,
  output logic              fsm_state
);

  localparam int REC_W = 100;
  localparam logic [7:0]      TIMER_INIT = 8'(HDR_TIMEOUT);
  localparam logic [ADDR_W:0] FULL_CNT   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, WAIT_HDR = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              capture, commit_req, type_ok;
  logic [7:0]        timer;
  logic [79:0]       ts_hold;
  logic              rec_vld;
  logic [3:0]        rec_type;
  logic [15:0]       rec_seq;
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic [REC_W-1:0]  mem [DEPTH];
  logic              full, do_pop, do_write, do_drop;

`ifdef PTP_TSQ_EVENT_FILTER_EN
  assign type_ok = (hdr_msg_type <= 4'h3);
`else
  assign type_ok = 1'b1;
`endif

  always_ff @(posedge ptp_clk or negedge ptp_rst_n) begin
    if (!ptp_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // An SFD landing on the FIFO write cycle of the previous frame is ignored:
  // one capture per frame.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    commit_req = 1'b0;
    case (state)
      IDLE: begin
        if (sfd_stb && !rec_vld) begin
          capture   = 1'b1;
          state_nxt = WAIT_HDR;
        end
      end
      WAIT_HDR: begin
        if (frm_abort) begin
          state_nxt = IDLE;
        end else if (sfd_stb) begin
          capture = 1'b1;
        end else if (hdr_vld) begin
          commit_req = hdr_is_ptp && type_ok;
          state_nxt  = IDLE;
        end else if (timer == 8'd1) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fsm_state = (state == WAIT_HDR);

  always_ff @(posedge ptp_clk or negedge ptp_rst_n) begin
    if (!ptp_rst_n) begin
      timer    <= '0;
      ts_hold  <= '0;
      rec_vld  <= 1'b0;
      rec_type <= '0;
      rec_seq  <= '0;
    end else begin
      if (capture) begin
        ts_hold <= ts_in;
        timer   <= TIMER_INIT;
      end else if (state == WAIT_HDR && state_nxt == WAIT_HDR) begin
        timer <= timer - 8'd1;
      end
      rec_vld <= commit_req;
      if (commit_req) begin
        rec_type <= hdr_msg_type;
        rec_seq  <= hdr_seq_id;
      end
    end
  end

  // pop is an accept strobe: it takes effect only while q_vld is high, and the
  // head entry is consumed on that edge.
  assign q_count  = wr_ptr - rd_ptr;
  assign q_vld    = (q_count != '0);
  assign full     = (q_count == FULL_CNT);
  assign do_pop   = pop && q_vld;
  assign do_write = rec_vld && (!full || do_pop);
  assign do_drop  = rec_vld && full && !do_pop;

  always_ff @(posedge ptp_clk or negedge ptp_rst_n) begin
    if (!ptp_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr[ADDR_W-1:0]] <= {ts_hold, rec_type, rec_seq};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Head is read straight from storage, so it keeps the last popped record when empty.
  assign {q_ts, q_msg_type, q_seq_id} = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge ptp_clk or negedge ptp_rst_n) begin
    if (!ptp_rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_stat) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (do_drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ptp_ts_queue.sv
// Self-checking bench for ptp_ts_queue: scoreboard of expected records, compared at the FIFO head.
module tb_ptp_ts_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sfd_stb = 1'b0;
  logic [79:0]       ts_in = '0;
  logic              hdr_vld = 1'b0;
  logic              hdr_is_ptp = 1'b0;
  logic [3:0]        hdr_msg_type = '0;
  logic [15:0]       hdr_seq_id = '0;
  logic              frm_abort = 1'b0;
  logic              pop = 1'b0;
  logic              clr_stat = 1'b0;
  logic              q_vld;
  logic [79:0]       q_ts;
  logic [3:0]        q_msg_type;
  logic [15:0]       q_seq_id;
  logic [ADDR_W:0]   q_count;
  logic              ovf;
  logic [7:0]        drop_cnt;
  logic              fsm_state;

  ptp_ts_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HDR_TIMEOUT(64)) dut (
    .ptp_clk(clk), .ptp_rst_n(rst_n), .sfd_stb(sfd_stb), .ts_in(ts_in),
    .hdr_vld(hdr_vld), .hdr_is_ptp(hdr_is_ptp), .hdr_msg_type(hdr_msg_type),
    .hdr_seq_id(hdr_seq_id), .frm_abort(frm_abort), .pop(pop),
    .q_vld(q_vld), .q_ts(q_ts), .q_msg_type(q_msg_type), .q_seq_id(q_seq_id),
    .q_count(q_count), .ovf(ovf), .drop_cnt(drop_cnt), .clr_stat(clr_stat),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [99:0] exp_q[$];
  int          exp_drop = 0;
  logic        exp_ovf = 1'b0;
  logic        vld_e0;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] rand_ts();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction

  task automatic model_commit(input logic [99:0] rec);
    if (exp_q.size() < DEPTH) exp_q.push_back(rec);
    else begin
      if (exp_drop < 255) exp_drop++;
      exp_ovf = 1'b1;
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_count"}, q_count, exp_q.size());
    check({tag, "_ovf"}, ovf, exp_ovf);
    check({tag, "_drop"}, drop_cnt, exp_drop);
  endtask

  task automatic check_head(input string tag);
    if (exp_q.size() == 0) check({tag, "_vld"}, q_vld, 1'b0);
    else check(tag, {q_ts, q_msg_type, q_seq_id}, exp_q[0]);
  endtask

  // SFD, then hdr_vld sampled 'gap' cycles later, then the FIFO write cycle.
  task automatic frame(input logic [79:0] ts, input logic [3:0] typ, input logic [15:0] seq,
                       input int gap, input logic is_ptp, input bit expect_rec, input bit with_pop);
    sfd_stb = 1'b1; ts_in = ts;
    tick();
    sfd_stb = 1'b0; ts_in = rand_ts();
    repeat (gap - 1) tick();
    hdr_vld = 1'b1; hdr_is_ptp = is_ptp; hdr_msg_type = typ; hdr_seq_id = seq;
    tick();
    hdr_vld = 1'b0; hdr_is_ptp = 1'b0; hdr_msg_type = 4'($urandom_range(0, 15));
    vld_e0 = q_vld;
    if (with_pop) begin
      check_head("commit_pop_head");
      pop = 1'b1;
    end
    tick();
    pop = 1'b0;
    if (with_pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (expect_rec) model_commit({ts, typ, seq});
  endtask

  task automatic pop_one();
    check_head("pop_head");
    pop = 1'b1;
    tick();
    pop = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_one();
    check({tag, "_empty"}, q_vld, 1'b0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    logic [79:0] ts_a, ts_b;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_vld", q_vld, 1'b0);
    check("rst_count", q_count, 0);
    check("rst_ts", q_ts, 0);
    check("rst_state", fsm_state, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    tick();

    // T1: basic capture, 2-cycle hdr_vld -> q_vld latency
    frame(80'h0000_0000_0001_0000_0064, 4'h0, 16'h1234, 5, 1'b1, 1'b1, 1'b0);
    check("t1_vld_e0", vld_e0, 1'b0);
    check("t1_vld", q_vld, 1'b1);
    check_head("t1_head");
    check_stats("t1");
    drain("t1");

    // T2: header timeout window (64 cycles commits, 65 does not), non-PTP header
    frame(rand_ts(), 4'h1, 16'h0002, 65, 1'b1, 1'b0, 1'b0);
    check("t2_state", fsm_state, 1'b0);
    check_stats("t2_tmo");
    frame(rand_ts(), 4'h2, 16'h0003, 64, 1'b1, 1'b1, 1'b0);
    frame(rand_ts(), 4'h0, 16'h0004, 1, 1'b1, 1'b1, 1'b0);
    frame(rand_ts(), 4'h0, 16'h0005, 3, 1'b0, 1'b0, 1'b0);
    check_stats("t2");
    drain("t2");

    // T4: abort, re-latch on repeated SFD, SFD beats hdr_vld, SFD blocked on write cycle
    sfd_stb = 1'b1; ts_in = rand_ts(); tick(); sfd_stb = 1'b0;
    tick();
    frm_abort = 1'b1; tick(); frm_abort = 1'b0;
    check("t4_abort_state", fsm_state, 1'b0);
    frame(rand_ts(), 4'h1, 16'h0B0B, 4, 1'b1, 1'b1, 1'b0);
    check_stats("t4_abort");
    sfd_stb = 1'b1; ts_in = rand_ts(); tick(); sfd_stb = 1'b0;
    tick(); tick();
    frame(rand_ts(), 4'h3, 16'h0D0D, 3, 1'b1, 1'b1, 1'b0);
    check_stats("t4_relatch");
    drain("t4_a");

    ts_a = rand_ts(); ts_b = rand_ts();
    sfd_stb = 1'b1; ts_in = ts_a; tick(); sfd_stb = 1'b0;
    tick();
    sfd_stb = 1'b1; ts_in = ts_b; hdr_vld = 1'b1; hdr_is_ptp = 1'b1; hdr_seq_id = 16'hEEEE;
    tick();
    sfd_stb = 1'b0; hdr_vld = 1'b0;
    check("t4_sfd_wins_state", fsm_state, 1'b1);
    tick();
    check("t4_sfd_wins_count", q_count, 0);
    hdr_vld = 1'b1; hdr_msg_type = 4'h2; hdr_seq_id = 16'hF00F;
    tick();
    hdr_vld = 1'b0; hdr_is_ptp = 1'b0;
    exp_q.push_back({ts_b, 4'h2, 16'hF00F});
    tick();
    check_head("t4_sfd_wins_head");
    drain("t4_b");

    sfd_stb = 1'b1; ts_in = ts_a; tick(); sfd_stb = 1'b0;
    tick();
    hdr_vld = 1'b1; hdr_is_ptp = 1'b1; hdr_msg_type = 4'h1; hdr_seq_id = 16'h7777;
    tick();
    hdr_vld = 1'b0; sfd_stb = 1'b1; ts_in = ts_b;
    tick();
    sfd_stb = 1'b0;
    exp_q.push_back({ts_a, 4'h1, 16'h7777});
    check("t4_nocap_state", fsm_state, 1'b0);
    hdr_vld = 1'b1; tick(); hdr_vld = 1'b0; hdr_is_ptp = 1'b0;
    tick(); tick();
    check_stats("t4_nocap");
    drain("t4_c");

    // T6: non-event messageType and the last event type
`ifdef PTP_TSQ_EVENT_FILTER_EN
    frame(rand_ts(), 4'hB, 16'h0606, 2, 1'b1, 1'b0, 1'b0);
`else
    frame(rand_ts(), 4'hB, 16'h0606, 2, 1'b1, 1'b1, 1'b0);
`endif
    frame(rand_ts(), 4'h3, 16'h0607, 2, 1'b1, 1'b1, 1'b0);
    check_stats("t6");
    drain("t6");

    // T3: full, drop, commit+pop, clear, clear-vs-drop, saturation
    for (int i = 0; i < DEPTH; i++)
      frame(rand_ts(), 4'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)),
            $urandom_range(1, 6), 1'b1, 1'b1, 1'b0);
    check_stats("t3_full");
    frame(rand_ts(), 4'h0, 16'h0999, 2, 1'b1, 1'b1, 1'b0);
    check_stats("t3_drop");
    check_head("t3_head_kept");
    frame(rand_ts(), 4'h1, 16'h0AAA, 2, 1'b1, 1'b1, 1'b1);
    check_stats("t3_commit_pop");
    clr_stat = 1'b1; tick(); clr_stat = 1'b0;
    exp_drop = 0; exp_ovf = 1'b0;
    check_stats("t3_clr");
    clr_stat = 1'b1;
    frame(rand_ts(), 4'h0, 16'h0BBB, 1, 1'b1, 1'b1, 1'b0);
    clr_stat = 1'b0;
    exp_drop = 0; exp_ovf = 1'b0;
    check_stats("t3_clr_wins");
    repeat (260) frame(rand_ts(), 4'h0, 16'($urandom_range(0, 65535)), 1, 1'b1, 1'b1, 1'b0);
    check_stats("t3_sat");
    drain("t3");
    pop = 1'b1; tick(); pop = 1'b0;
    check("t3_empty_pop_count", q_count, 0);

    // T5: async reset while capturing with entries queued
    for (int i = 0; i < 3; i++)
      frame(rand_ts(), 4'h0, 16'(i + 16'h0500), 2, 1'b1, 1'b1, 1'b0);
    sfd_stb = 1'b1; ts_in = rand_ts(); tick(); sfd_stb = 1'b0;
    check("t5_pre_state", fsm_state, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_vld", q_vld, 1'b0);
    check("t5_count", q_count, 0);
    check("t5_ts", q_ts, 0);
    check("t5_seq", q_seq_id, 0);
    check("t5_ovf", ovf, 1'b0);
    check("t5_drop", drop_cnt, 0);
    check("t5_state", fsm_state, 1'b0);
    exp_q.delete(); exp_drop = 0; exp_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pop = 1'b1; tick(); pop = 1'b0;
    check_stats("t5_pop");
    frame(rand_ts(), 4'h2, 16'h5A5A, 3, 1'b1, 1'b1, 1'b0);
    check_stats("t5_after");
    drain("t5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
